// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter sharing one block-RAM port, with registered issue
// and a latency-matched tag pipe that steers read data back to its owner.
module bram_port_arbiter #(
  parameter int DATA     = 8,
  parameter int ADDR     = 15,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_req,
  input  logic            r0_wr,
  input  logic [ADDR-1:0] r0_addr,
  input  logic [DATA-1:0] r0_din,
  output logic            r0_ack,
  output logic            r0_rvalid,
  input  logic            r1_req,
  input  logic            r1_wr,
  input  logic [ADDR-1:0] r1_addr,
  input  logic [DATA-1:0] r1_din,
  output logic            r1_ack,
  output logic            r1_rvalid,
  output logic [DATA-1:0] rdata,
  output logic            m_en,
  output logic            m_wr,
  output logic [ADDR-1:0] m_addr,
  output logic [DATA-1:0] m_din,
  input  logic [DATA-1:0] m_dout
);

  logic            gnt0;
  logic            gnt1;
  logic            xfer;
  logic            sel_wr;
  logic [ADDR-1:0] sel_addr;
  logic [DATA-1:0] sel_din;

  logic            last_gnt_q;
  logic            last_gnt_d;
  logic            m_en_q;
  logic            m_en_d;
  logic            m_wr_q;
  logic            m_wr_d;
  logic [ADDR-1:0] m_addr_q;
  logic [ADDR-1:0] m_addr_d;
  logic [DATA-1:0] m_din_q;
  logic [DATA-1:0] m_din_d;

  // stage k holds the tag of an access issued k+1 cycles ago
  logic [RD_LAT:0] tag_vld_q;
  logic [RD_LAT:0] tag_vld_d;
  logic [RD_LAT:0] tag_own_q;
  logic [RD_LAT:0] tag_own_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case ({r0_req, r1_req})
        2'b10: gnt0 = 1'b1;
        2'b01: gnt1 = 1'b1;
        2'b11: begin
          // last_gnt_q high means r1 won last, so r0 gets the tie
          if (ARB_MODE != 0 || last_gnt_q) gnt0 = 1'b1;
          else gnt1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign r0_ack = gnt0;
  assign r1_ack = gnt1;
  assign xfer   = gnt0 | gnt1;

  always_comb begin
    sel_wr   = r0_wr;
    sel_addr = r0_addr;
    sel_din  = r0_din;
    if (gnt1) begin
      sel_wr   = r1_wr;
      sel_addr = r1_addr;
      sel_din  = r1_din;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    m_en_d     = xfer;
    m_wr_d     = xfer & sel_wr;
    m_addr_d   = m_addr_q;
    m_din_d    = m_din_q;
    if (xfer) begin
      last_gnt_d = gnt1;
      m_addr_d   = sel_addr;
      m_din_d    = sel_din;
    end
    tag_vld_d = {tag_vld_q[RD_LAT-1:0], xfer & ~sel_wr};
    tag_own_d = {tag_own_q[RD_LAT-1:0], gnt1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
      m_en_q     <= 1'b0;
      m_wr_q     <= 1'b0;
      m_addr_q   <= '0;
      m_din_q    <= '0;
      tag_vld_q  <= '0;
      tag_own_q  <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      m_en_q     <= m_en_d;
      m_wr_q     <= m_wr_d;
      m_addr_q   <= m_addr_d;
      m_din_q    <= m_din_d;
      tag_vld_q  <= tag_vld_d;
      tag_own_q  <= tag_own_d;
    end
  end

  assign m_en   = m_en_q;
  assign m_wr   = m_wr_q;
  assign m_addr = m_addr_q;
  assign m_din  = m_din_q;

  assign r0_rvalid = tag_vld_q[RD_LAT] & ~tag_own_q[RD_LAT];
  assign r1_rvalid = tag_vld_q[RD_LAT] &  tag_own_q[RD_LAT];

  // unregistered pass of RAM data, forced to zero outside a return slot
  assign rdata = tag_vld_q[RD_LAT] ? m_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: three builds (RR/lat1, fixed/lat1, RR/lat3)
// each attached to a behavioural RAM, checked against a reference model.
module tb_bram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [3];
  logic          r0_req    [3];
  logic          r0_wr     [3];
  logic [AW-1:0] r0_addr   [3];
  logic [DW-1:0] r0_din    [3];
  logic          r0_ack    [3];
  logic          r0_rvalid [3];
  logic          r1_req    [3];
  logic          r1_wr     [3];
  logic [AW-1:0] r1_addr   [3];
  logic [DW-1:0] r1_din    [3];
  logic          r1_ack    [3];
  logic          r1_rvalid [3];
  logic [DW-1:0] rdata     [3];
  logic          m_en      [3];
  logic          m_wr      [3];
  logic [AW-1:0] m_addr    [3];
  logic [DW-1:0] m_din     [3];
  logic [DW-1:0] m_dout    [3];

  int n_pass  = 0;
  int n_total = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 2) ? 3 : 1;
    localparam int AM = (g == 1) ? 1 : 0;

    bram_port_arbiter #(
      .DATA(DW), .ADDR(AW), .RD_LAT(RL), .ARB_MODE(AM)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .r0_req   (r0_req[g]),
      .r0_wr    (r0_wr[g]),
      .r0_addr  (r0_addr[g]),
      .r0_din   (r0_din[g]),
      .r0_ack   (r0_ack[g]),
      .r0_rvalid(r0_rvalid[g]),
      .r1_req   (r1_req[g]),
      .r1_wr    (r1_wr[g]),
      .r1_addr  (r1_addr[g]),
      .r1_din   (r1_din[g]),
      .r1_ack   (r1_ack[g]),
      .r1_rvalid(r1_rvalid[g]),
      .rdata    (rdata[g]),
      .m_en     (m_en[g]),
      .m_wr     (m_wr[g]),
      .m_addr   (m_addr[g]),
      .m_din    (m_din[g]),
      .m_dout   (m_dout[g])
    );

    // behavioural RAM port with RL cycles of read latency
    logic [DW-1:0] mem  [1<<AW];
    logic [DW-1:0] pipe [RL];

    initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      for (int i = 0; i < RL; i++) pipe[i] = '0;
    end

    always @(posedge clk) begin
      if (m_en[g] && m_wr[g]) mem[m_addr[g]] <= m_din[g];
      if (m_en[g] && !m_wr[g]) pipe[0] <= mem[m_addr[g]];
      else pipe[0] <= 8'hEE;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    assign m_dout[g] = pipe[RL-1];
  end

  task automatic idle(input int d);
    r0_req[d]  = 1'b0;
    r0_wr[d]   = 1'b0;
    r0_addr[d] = '0;
    r0_din[d]  = '0;
    r1_req[d]  = 1'b0;
    r1_wr[d]   = 1'b0;
    r1_addr[d] = '0;
    r1_din[d]  = '0;
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    idle(d);
    @(negedge clk);
    @(negedge clk);
    rst[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      idle(d);
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      r0_req[d] = 1'b1;
      r1_req[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if ({r0_ack[d], r1_ack[d]} !== 2'b00)
        $display("FAIL reset_ack[%0d]: got %b want 00", d, {r0_ack[d], r1_ack[d]});
      else n_pass++;
      n_total++;
      if ({m_en[d], m_wr[d], r0_rvalid[d], r1_rvalid[d]} !== 4'b0000)
        $display("FAIL reset_ctl[%0d]: got %b want 0000", d,
                 {m_en[d], m_wr[d], r0_rvalid[d], r1_rvalid[d]});
      else n_pass++;
      n_total++;
      if ({m_addr[d], m_din[d], rdata[d]} !== '0)
        $display("FAIL reset_data[%0d]: got %h/%h/%h want 0", d,
                 m_addr[d], m_din[d], rdata[d]);
      else n_pass++;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      idle(d);
      rst[d] = 1'b0;
    end
  endtask

  task automatic test_write_read();
    do_reset(0);
    @(negedge clk);
    r0_req[0] = 1'b1; r0_wr[0] = 1'b1;
    r0_addr[0] = 15'h0010; r0_din[0] = 8'h5A;
    #1;
    n_total++;
    if (r0_ack[0] !== 1'b1) $display("FAIL wr_ack: got %b want 1", r0_ack[0]);
    else n_pass++;
    @(negedge clk);
    r0_wr[0] = 1'b0; r0_din[0] = 8'h00;
    #1;
    n_total++;
    if (r0_ack[0] !== 1'b1) $display("FAIL rd_ack: got %b want 1", r0_ack[0]);
    else n_pass++;
    n_total++;
    if ({m_en[0], m_wr[0], m_addr[0], m_din[0]} !== {2'b11, 15'h0010, 8'h5A})
      $display("FAIL wr_issue: got %b%b %h %h want 11 0010 5a",
               m_en[0], m_wr[0], m_addr[0], m_din[0]);
    else n_pass++;
    @(negedge clk);
    idle(0);
    n_total++;
    if ({m_en[0], m_wr[0], r0_rvalid[0]} !== 3'b100)
      $display("FAIL rd_issue: got %b want 100", {m_en[0], m_wr[0], r0_rvalid[0]});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({r0_rvalid[0], r1_rvalid[0], rdata[0]} !== {2'b10, 8'h5A})
      $display("FAIL rd_return: got %b%b %h want 10 5a",
               r0_rvalid[0], r1_rvalid[0], rdata[0]);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({m_en[0], r0_rvalid[0]} !== 2'b00)
      $display("FAIL rd_after: got %b want 00", {m_en[0], r0_rvalid[0]});
    else n_pass++;
  endtask

  task automatic test_contention(input int d, input bit fixed);
    bit last;
    bit e0;
    do_reset(d);
    last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      r0_req[d] = 1'b1; r0_addr[d] = AW'(i);
      r1_req[d] = 1'b1; r1_addr[d] = AW'(i + 32);
      #1;
      e0 = fixed ? 1'b1 : last;
      n_total++;
      if ({r0_ack[d], r1_ack[d]} !== {e0, ~e0})
        $display("FAIL contend[%0d] cyc%0d: got %b want %b", d, i,
                 {r0_ack[d], r1_ack[d]}, {e0, ~e0});
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (m_en[d] !== 1'b1)
          $display("FAIL contend_men[%0d] cyc%0d: got %b want 1", d, i, m_en[d]);
        else n_pass++;
      end
      last = ~e0;
    end
    @(negedge clk);
    idle(d);
    n_total++;
    if (m_en[d] !== 1'b1)
      $display("FAIL contend_men_last[%0d]: got %b want 1", d, m_en[d]);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_interleave();
    do_reset(0);
    @(negedge clk);
    r1_req[0] = 1'b1; r1_wr[0] = 1'b1; r1_addr[0] = 15'h0100; r1_din[0] = 8'hC3;
    @(negedge clk);
    idle(0);
    r0_req[0] = 1'b1; r0_wr[0] = 1'b1; r0_addr[0] = 15'h0101; r0_din[0] = 8'h3C;
    @(negedge clk);
    idle(0);
    @(negedge clk);
    r1_req[0] = 1'b1; r1_addr[0] = 15'h0100;
    #1;
    n_total++;
    if (r1_ack[0] !== 1'b1) $display("FAIL il_ack1: got %b want 1", r1_ack[0]);
    else n_pass++;
    @(negedge clk);
    idle(0);
    r0_req[0] = 1'b1; r0_addr[0] = 15'h0101;
    #1;
    n_total++;
    if (r0_ack[0] !== 1'b1) $display("FAIL il_ack0: got %b want 1", r0_ack[0]);
    else n_pass++;
    @(negedge clk);
    idle(0);
    n_total++;
    if ({r0_rvalid[0], r1_rvalid[0], rdata[0]} !== {2'b01, 8'hC3})
      $display("FAIL il_ret1: got %b%b %h want 01 c3",
               r0_rvalid[0], r1_rvalid[0], rdata[0]);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({r0_rvalid[0], r1_rvalid[0], rdata[0]} !== {2'b10, 8'h3C})
      $display("FAIL il_ret0: got %b%b %h want 10 3c",
               r0_rvalid[0], r1_rvalid[0], rdata[0]);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({r0_rvalid[0], r1_rvalid[0]} !== 2'b00)
      $display("FAIL il_quiet: got %b want 00", {r0_rvalid[0], r1_rvalid[0]});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    @(negedge clk);
    r0_req[0] = 1'b1; r0_addr[0] = 15'h0010;
    #1;
    n_total++;
    if (r0_ack[0] !== 1'b1) $display("FAIL rm_ack: got %b want 1", r0_ack[0]);
    else n_pass++;
    @(negedge clk);
    idle(0);
    rst[0] = 1'b1;
    #1;
    n_total++;
    if ({m_en[0], r0_ack[0]} !== 2'b10)
      $display("FAIL rm_inflight: got %b want 10", {m_en[0], r0_ack[0]});
    else n_pass++;
    @(negedge clk);
    rst[0] = 1'b0;
    n_total++;
    if ({m_en[0], r0_rvalid[0], r1_rvalid[0], rdata[0]} !== {3'b000, 8'h00})
      $display("FAIL rm_flush: got %b%b%b %h want 000 00",
               m_en[0], r0_rvalid[0], r1_rvalid[0], rdata[0]);
    else n_pass++;
    r0_req[0] = 1'b1; r0_wr[0] = 1'b1; r0_addr[0] = 15'h0020;
    r1_req[0] = 1'b1; r1_wr[0] = 1'b1; r1_addr[0] = 15'h0021;
    #1;
    n_total++;
    if ({r0_ack[0], r1_ack[0]} !== 2'b10)
      $display("FAIL rm_tie: got %b want 10", {r0_ack[0], r1_ack[0]});
    else n_pass++;
    @(negedge clk);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({r0_rvalid[0], r1_rvalid[0]} !== 2'b00)
        $display("FAIL rm_none%0d: got %b want 00", i, {r0_rvalid[0], r1_rvalid[0]});
      else n_pass++;
    end
  endtask

  typedef struct {
    int       due;
    bit       owner;
    bit [7:0] data;
  } ret_t;

  task automatic test_random_lat3();
    ret_t     q[$];
    ret_t     e;
    bit [7:0] ref_mem [16];
    bit       last;
    bit       acked0;
    bit       acked1;
    bit       e0;
    bit       e1;
    bit       x0;
    bit       x1;
    bit [7:0] xd;
    int       a;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    do_reset(2);
    last = 1'b1;
    acked0 = 1'b1;
    acked1 = 1'b1;
    for (int k = 0; k < 2010; k++) begin
      @(negedge clk);
      x0 = 1'b0; x1 = 1'b0; xd = '0;
      if (q.size() > 0 && q[0].due == k) begin
        e = q.pop_front();
        x0 = ~e.owner;
        x1 = e.owner;
        xd = e.data;
      end
      n_total++;
      if ({r0_rvalid[2], r1_rvalid[2]} !== {x0, x1})
        $display("FAIL rnd_rvalid k=%0d: got %b want %b", k,
                 {r0_rvalid[2], r1_rvalid[2]}, {x0, x1});
      else n_pass++;
      if (x0 || x1) begin
        n_total++;
        if (rdata[2] !== xd)
          $display("FAIL rnd_rdata k=%0d: got %h want %h", k, rdata[2], xd);
        else n_pass++;
      end
      if (k >= 2000) begin
        idle(2);
      end else begin
        if (acked0 || !r0_req[2]) begin
          r0_req[2]  = ($urandom_range(0, 3) != 0);
          r0_wr[2]   = 1'($urandom_range(0, 1));
          r0_addr[2] = AW'($urandom_range(0, 15));
          r0_din[2]  = DW'($urandom);
        end
        if (acked1 || !r1_req[2]) begin
          r1_req[2]  = ($urandom_range(0, 3) != 0);
          r1_wr[2]   = 1'($urandom_range(0, 1));
          r1_addr[2] = AW'($urandom_range(0, 15));
          r1_din[2]  = DW'($urandom);
        end
      end
      #1;
      e0 = r0_req[2] && (!r1_req[2] || last);
      e1 = r1_req[2] && !e0;
      n_total++;
      if ({r0_ack[2], r1_ack[2]} !== {e0, e1})
        $display("FAIL rnd_ack k=%0d: got %b want %b", k,
                 {r0_ack[2], r1_ack[2]}, {e0, e1});
      else n_pass++;
      if (e0) begin
        a = int'(r0_addr[2][3:0]);
        if (r0_wr[2]) ref_mem[a] = r0_din[2];
        else q.push_back('{due: k + 4, owner: 1'b0, data: ref_mem[a]});
        last = 1'b0;
      end else if (e1) begin
        a = int'(r1_addr[2][3:0]);
        if (r1_wr[2]) ref_mem[a] = r1_din[2];
        else q.push_back('{due: k + 4, owner: 1'b1, data: ref_mem[a]});
        last = 1'b1;
      end
      acked0 = e0;
      acked1 = e1;
    end
    n_total++;
    if (q.size() != 0)
      $display("FAIL rnd_drain: got %0d pending want 0", q.size());
    else n_pass++;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      idle(d);
    end
    test_reset();
    test_write_read();
    test_contention(0, 1'b0);
    test_contention(1, 1'b1);
    test_interleave();
    test_reset_mid();
    test_random_lat3();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
